// File: rtl/nios_sd_clk_gen.sv
// nios_sd_clk_gen: Avalon-MM SD card clock generator with manual level control,
// counted bursts and free-run at a programmable half-period.
module nios_sd_clk_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int RESET_DIV = 62
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        rise_pulse,
  output logic        busy
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic data_q, data_d, mode_q, mode_d, free_q, free_d;
  logic out_q, out_d, rise_q, rise_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, div_act_q, div_act_d, cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d, wr_cnt;
  logic we, cnt_wr, start, edge_hit, stop, unused_bits;
  assign we = chipselect && !write_n;
  assign wr_cnt = writedata[CNT_WIDTH-1:0];
  assign cnt_wr = we && address == 2'd3 && wr_cnt != '0;
  assign unused_bits = ^writedata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= 1'b0;
      mode_q    <= 1'b0;
      free_q    <= 1'b0;
      div_q     <= DIV_WIDTH'(RESET_DIV);
      div_act_q <= DIV_WIDTH'(RESET_DIV);
      cnt_q     <= '0;
      rem_q     <= '0;
      out_q     <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      free_q    <= free_d;
      div_q     <= div_d;
      div_act_q <= div_act_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
    end
  end
  // Free-run start looks at the post-write CTRL so a CTRL=3 write starts on its own edge.
  always_comb begin
    data_d    = (we && address == 2'd0) ? writedata[0] : data_q;
    mode_d    = (we && address == 2'd1) ? writedata[0] : mode_q;
    free_d    = (we && address == 2'd1) ? writedata[1] : free_q;
    div_d     = (we && address == 2'd2) ? writedata[DIV_WIDTH-1:0] : div_q;
    start     = cnt_wr || free_d;
    edge_hit  = cnt_q == div_act_q;
    stop      = out_q && rem_q == '0 && !free_q;
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    out_d     = out_q;
    rise_d    = 1'b0;
    if (!mode_d) begin
      state_d = IDLE;
      rem_d   = '0;
      cnt_d   = '0;
      out_d   = data_d;
    end else if (state_q == IDLE) begin
      out_d = 1'b0;
      if (start) begin
        state_d   = RUN;
        rem_d     = cnt_wr ? wr_cnt : '0;
        cnt_d     = '0;
        div_act_d = div_q;
      end
    end else if (edge_hit) begin
      out_d     = !out_q;
      cnt_d     = '0;
      div_act_d = div_q;
      rise_d    = !out_q;
      rem_d     = (!out_q && rem_q != '0) ? rem_q - 1'b1 : rem_q;
      state_d   = stop ? IDLE : RUN;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_comb begin
    busy       = state_q == RUN;
    out_port   = out_q;
    rise_pulse = rise_q;
    readdata   = address == 2'd0 ? {31'b0, out_q} :
                 address == 2'd1 ? {23'b0, busy, 6'b0, free_q, mode_q} :
                 address == 2'd2 ? 32'(div_q) : 32'(rem_q);
  end
endmodule

// File: tb/tb_nios_sd_clk_gen.sv
// tb_nios_sd_clk_gen: randomized bursts checked against a closed-form waveform model,
// plus free-run, abort and asynchronous reset scenarios.
module tb_nios_sd_clk_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        out_port, rise_pulse, busy;
  int checks = 0;
  int errors = 0;

  nios_sd_clk_gen dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .rise_pulse(rise_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    int n_p, d_p, len, ph, rises, n;
    logic [31:0] v;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out", 32'(out_port), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rise", 32'(rise_pulse), 0);
    rd(0, "rst_data", 0);
    rd(1, "rst_ctrl", 0);
    rd(2, "rst_div", 62);
    rd(3, "rst_count", 0);
    // manual mode: registered level, no strobes
    wr(0, 1);
    check("man_hi", 32'(out_port), 1);
    check("man_rise", 32'(rise_pulse), 0);
    wr(0, 0);
    check("man_lo", 32'(out_port), 0);
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      wr(0, v);
      check("man_rnd", 32'(out_port), 32'(v[0]));
      check("man_rnd_rise", 32'(rise_pulse), 0);
      rd(0, "man_rd", 32'(v[0]));
    end
    // bursts: first is DIV=0,N=1; odd iterations keep DIV so the write lands right after busy falls
    wr(0, 0);
    wr(1, 1);
    d_p = 0;
    wr(2, {16'($urandom), 16'(d_p)});
    n_p = 1;
    for (int it = 0; it < 12; it++) begin
      if (it == 1) begin
        d_p = 3;
        n_p = 4;
        wr(2, {16'($urandom), 16'(d_p)});
      end else if (it > 1) begin
        n_p = $urandom_range(1, 5);
        if (it % 2 == 0) begin
          d_p = $urandom_range(0, 5);
          wr(2, {16'($urandom), 16'(d_p)});
        end
      end
      wr(3, {16'($urandom), 16'(n_p)});
      len = 2 * n_p * (d_p + 1);
      for (int k = 0; k <= len; k++) begin
        ph = k / (d_p + 1);
        rises = (k < d_p + 1) ? 0 : (k - (d_p + 1)) / (2 * (d_p + 1)) + 1;
        if (rises > n_p) rises = n_p;
        check("burst_out", 32'(out_port), 32'(k < len && ph % 2 == 1));
        check("burst_busy", 32'(busy), 32'(k < len));
        check("burst_rise", 32'(rise_pulse), 32'(k < len && ph % 2 == 1 && k % (d_p + 1) == 0));
        check("burst_count", readdata, 32'(n_p - rises));
        if (k == 1) begin
          writedata = 9;
          chipselect = 1'b1;
          write_n = 1'b0;
        end
        if (k < len) begin
          step();
          chipselect = 1'b0;
          write_n = 1'b1;
        end
      end
    end
    // free-run at DIV=1, then DIV=4 written mid-phase
    wr(2, 1);
    wr(1, 3);
    for (int k = 0; k <= 12; k++) begin
      check("free_out", 32'(out_port), 32'((k / 2) % 2));
      check("free_busy", 32'(busy), 1);
      if (k < 12) step();
    end
    wr(2, 4);
    check("free_mid", 32'(out_port), 0);
    step();
    check("free_rise", 32'(rise_pulse), 1);
    n = 0;
    while (out_port === 1'b1 && n < 50) begin n++; step(); end
    check("free_hi5", 32'(n), 5);
    n = 0;
    while (out_port === 1'b0 && n < 50) begin n++; step(); end
    check("free_lo5", 32'(n), 5);
    step();
    wr(1, 1);
    n = 2;
    while (out_port === 1'b1 && n < 50) begin n++; step(); end
    check("stop_hi", 32'(n), 5);
    check("stop_busy", 32'(busy), 0);
    repeat (6) step();
    check("stop_low", 32'(out_port), 0);
    check("stop_busy2", 32'(busy), 0);
    // abort by clearing MODE mid-burst
    wr(0, 1);
    check("auto_idle_out", 32'(out_port), 0);
    wr(2, 0);
    wr(3, 100);
    repeat (3) step();
    rd(1, "ctrl_busy", 32'h101);
    wr(1, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_out", 32'(out_port), 1);
    rd(3, "abort_count", 0);
    // asynchronous reset during a high phase
    wr(0, 0);
    wr(1, 1);
    wr(2, 2);
    wr(3, 100);
    repeat (4) step();
    check("pre_rst_out", 32'(out_port), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_out", 32'(out_port), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_rise", 32'(rise_pulse), 0);
    rd(2, "arst_div", 62);
    rd(1, "arst_ctrl", 0);
    rd(3, "arst_count", 0);
    step();
    reset = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nios_sd_clk_gen.md
# nios_sd_clk_gen

Parametrised Avalon-MM SD clock generator for the Nios system, the successor to the single-bit software-toggled SD clock port. Keeps a manual (bit-bang) mode and adds a hardware mode that emits a programmable number of clock pulses, or a free-running clock, at a programmable divide ratio. Software gets a busy flag, and the SD data path gets a rising-edge strobe. Sits on the Nios data master and drives the SD card CLK pin directly.

## Interface
- DIV_WIDTH, 16: width of the half-period divider register.
- CNT_WIDTH, 16: width of the pulse-count register.
- RESET_DIV, 62: divider value after reset. 50 MHz / (2·63) ≈ 397 kHz, the SD identification rate.
- clk  in  1  system clock. All logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data. Combinational from `address`, not gated by `chipselect`, zero-wait. Unused bits read 0.
- out_port  out  1  SD clock output.
- rise_pulse  out  1  single-cycle strobe on each 0→1 transition of `out_port` in auto mode.
- busy  out  1  high while a burst or free run is active.

## Operation
- Write condition: `chipselect && !write_n`.
- Register map:
  - addr 0 DATA:
    - Write bit0 = manual level.
    - Read bit0 = current `out_port`.
  - addr 1 CTRL:
    - bit0 MODE (0 manual, 1 auto).
    - bit1 FREE (free-run enable).
    - Read additionally returns bit8 = `busy`.
  - addr 2 DIV: half-period of DIV+1 clk cycles. Reads back the programmed value.
  - addr 3 COUNT:
    - Write N>0 in auto mode while idle: start a burst of N clock pulses.
    - Read: remaining rising edges.
- Reset values:
  - `out_port` = 0, `rise_pulse` = 0, `busy` = 0.
  - DATA = 0, MODE = 0, FREE = 0, DIV = RESET_DIV, remaining = 0.
  - State IDLE, divider counter = 0.
- Manual mode: `out_port` = DATA bit0, registered. Its timing is equivalent to the legacy port. The generator is held in IDLE.
- Auto mode state machine:
  - IDLE:
    - `out_port` = 0.
    - Go to RUN on a COUNT write with N≠0. Load remaining = N, divider counter = 0, latch div_active = DIV.
    - Go to RUN when FREE is set (1→ or written 1 while idle), with the same loads and remaining = 0.
  - RUN, each clk:
    - If counter == div_active: toggle `out_port`, counter ← 0, latch div_active ← DIV (DIV changes apply at the next half-period boundary).
    - Otherwise counter++.
  - On a rising toggle: remaining−1 (burst only) and `rise_pulse` = 1 for that one cycle.
  - On a falling toggle:
    - Burst (FREE = 0), remaining == 0 → IDLE.
    - FREE cleared and not in a burst → IDLE.
    - The clock always stops low after a complete high phase. No runt pulses.
- Boundary rules:
  - COUNT write while `busy` → ignored. COUNT write of 0 → no action.
  - FREE cleared during a burst → the burst completes normally.
  - FREE set during a burst → continues free-running after the remaining pulses.
  - MODE written 0 while `busy` → immediate abort on that edge: state IDLE, remaining = 0, `busy` = 0, `out_port` = DATA bit0.
  - COUNT width: writedata[CNT_WIDTH-1:0]. DIV: writedata[DIV_WIDTH-1:0]. Upper bits are ignored.
  - `reset` mid-burst → all reset values asynchronously. No pulse completes.

## Timing
- Register writes take effect on the clk edge that samples the write (E0).
- Burst start with N pulses:
  - After E0: `busy` = 1, `out_port` = 0.
  - `out_port` rises after edge E0+(DIV+1) and falls after E0+2(DIV+1).
  - The Nth falling edge is at E0+2N(DIV+1). `busy` deasserts on that same edge.
  - Total burst: 2N(DIV+1) cycles. Duty cycle exactly 50 %.
- `rise_pulse` is high in exactly the first cycle `out_port` = 1.
- Reads are combinational. They reflect register state after the most recent edge.
- Back-to-back: a COUNT write on the cycle after `busy` falls starts a new burst with no lost cycles.

## Test plan
- Reset, then read all addresses → DATA 0, CTRL 0, DIV 62, COUNT 0. `out_port` = 0, `busy` = 0.
- Manual mode: write DATA=1 → `out_port` = 1 the next cycle. Write DATA=0 → 0. `rise_pulse` stays 0.
- CTRL=1, DIV=0, COUNT=1 → `out_port` high after E1, low after E2, `busy` low after E2, one `rise_pulse`.
- DIV=3, COUNT=4 → 4 pulses of 4 high / 4 low cycles, `busy` for 32 cycles, COUNT reads 3,2,1,0. A COUNT=9 write mid-burst is ignored.
- FREE=1, DIV=1 → continuous 2/2 clock. Write DIV=4 mid-phase → the next half-period is 5 cycles. Clear FREE during a high phase → stops after that falling edge, `busy` = 0.
- COUNT=100 then write CTRL=0 with DATA=1 → same edge `busy` = 0, `out_port` = 1. Assert `reset` mid-burst → all outputs 0 immediately.
